// File: rtl/ann_pkg.sv
// Shared types and constants for the ANN output classifier.
// Holds the FSM state type, the 7-segment glyph table and the default confidence margin.
package ann_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } cls_state_t;

    // Segment glyphs, bit order {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    localparam logic [15:0] MARGIN_DEF = 16'h0040;

endpackage

// File: rtl/ann_output_classifier_if.sv
// Handshake/result bundle between the ANN core, the classifier and the display side.
interface ann_output_classifier_if #(
    parameter int unsigned NUM_CLASSES = 10,
    parameter int unsigned DATA_W      = 16
);
    logic                                done_processing;
    logic [NUM_CLASSES-1:0][DATA_W-1:0]  scores;
    logic                                busy;
    logic                                result_valid;
    logic [3:0]                          digit;
    logic                                low_conf;
    logic [7:0]                          seven_seg;

    modport master (
        output done_processing, scores,
        input  busy, result_valid, digit, low_conf, seven_seg
    );

    modport slave (
        input  done_processing, scores,
        output busy, result_valid, digit, low_conf, seven_seg
    );
endinterface

// File: rtl/ann_output_classifier_seg7_encoder.sv
// Combinational hex digit to 7-segment glyph lookup.
module seg7_encoder
    import ann_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_c_o
);

    always_comb begin
        seg_c_o = SEG_0;
        case (digit_i)
            4'h0: seg_c_o = SEG_0;
            4'h1: seg_c_o = SEG_1;
            4'h2: seg_c_o = SEG_2;
            4'h3: seg_c_o = SEG_3;
            4'h4: seg_c_o = SEG_4;
            4'h5: seg_c_o = SEG_5;
            4'h6: seg_c_o = SEG_6;
            4'h7: seg_c_o = SEG_7;
            4'h8: seg_c_o = SEG_8;
            4'h9: seg_c_o = SEG_9;
            4'hA: seg_c_o = SEG_A;
            4'hB: seg_c_o = SEG_B;
            4'hC: seg_c_o = SEG_C;
            4'hD: seg_c_o = SEG_D;
            4'hE: seg_c_o = SEG_E;
            4'hF: seg_c_o = SEG_F;
        endcase
    end

endmodule

// File: rtl/ann_output_classifier.sv
// Snapshots the final-layer scores on a done rising edge, scans them serially for
// argmax and runner-up, then registers the class digit, confidence flag and display.
module ann_output_classifier
    import ann_pkg::*;
#(
    parameter int unsigned       NUM_CLASSES = 10,
    parameter int unsigned       DATA_W      = 16,
    parameter logic [DATA_W-1:0] MARGIN      = DATA_W'(MARGIN_DEF)
) (
    input  logic                    clk,
    input  logic                    rst,
    ann_output_classifier_if.slave  bus
);

    localparam int unsigned          IDX_W    = 4;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_CLASSES - 1);
    localparam logic [DATA_W-1:0]    MIN_VAL  = {1'b1, {(DATA_W-1){1'b0}}};

    typedef logic [NUM_CLASSES-1:0][DATA_W-1:0] snap_t;

    cls_state_t                 state_q, state_d;
    logic                       done_q, done_d;
    logic                       armed_q, armed_d;
    snap_t                      snap_q, snap_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic signed [DATA_W-1:0]   best_q, best_d;
    logic signed [DATA_W-1:0]   second_q, second_d;
    logic [3:0]                 best_idx_q, best_idx_d;
    logic                       busy_q, busy_d;
    logic                       valid_q, valid_d;
    logic [3:0]                 digit_q, digit_d;
    logic                       low_conf_q, low_conf_d;
    logic [7:0]                 seg_q, seg_d;

    logic                       start_c;
    logic signed [DATA_W-1:0]   cur_c;
    logic [DATA_W:0]            diff_c;
    logic                       low_conf_c;
    logic [6:0]                 glyph_c;

    seg7_encoder u_seg7 (
        .digit_i (best_idx_q),
        .seg_c_o (glyph_c)
    );

    // armed_q blocks a start until done has been seen low since reset,
    // so a level held high across reset never launches a classification.
    assign start_c    = bus.done_processing & ~done_q & armed_q;
    assign cur_c      = snap_q[idx_q];
    assign diff_c     = {best_q[DATA_W-1], best_q} - {second_q[DATA_W-1], second_q};
    assign low_conf_c = (diff_c < {1'b0, MARGIN});

    always_comb begin
        state_d    = state_q;
        done_d     = bus.done_processing;
        armed_d    = armed_q | ~bus.done_processing;
        snap_d     = snap_q;
        idx_d      = idx_q;
        best_d     = best_q;
        second_d   = second_q;
        best_idx_d = best_idx_q;
        valid_d    = 1'b0;
        digit_d    = digit_q;
        low_conf_d = low_conf_q;
        seg_d      = seg_q;

        case (state_q)
            IDLE: begin
                if (start_c) begin
                    snap_d     = bus.scores;
                    idx_d      = '0;
                    best_d     = MIN_VAL;
                    second_d   = MIN_VAL;
                    best_idx_d = '0;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                // Strict compares keep the lowest index on ties
                if (cur_c > best_q) begin
                    second_d   = best_q;
                    best_d     = cur_c;
                    best_idx_d = 4'(idx_q);
                end else if (cur_c > second_q) begin
                    second_d = cur_c;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                digit_d    = best_idx_q;
                low_conf_d = low_conf_c;
                seg_d      = {low_conf_c, glyph_c};
                valid_d    = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            done_q     <= 1'b0;
            armed_q    <= 1'b0;
            snap_q     <= '0;
            idx_q      <= '0;
            best_q     <= '0;
            second_q   <= '0;
            best_idx_q <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            digit_q    <= '0;
            low_conf_q <= 1'b0;
            seg_q      <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            armed_q    <= armed_d;
            snap_q     <= snap_d;
            idx_q      <= idx_d;
            best_q     <= best_d;
            second_q   <= second_d;
            best_idx_q <= best_idx_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            digit_q    <= digit_d;
            low_conf_q <= low_conf_d;
            seg_q      <= seg_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.result_valid = valid_q;
    assign bus.digit        = digit_q;
    assign bus.low_conf     = low_conf_q;
    assign bus.seven_seg    = seg_q;

endmodule

// File: tb/tb_ann_output_classifier.sv
// Scoreboard bench for ann_output_classifier: stimulus pushes reference results,
// a negedge monitor pops and compares on every result_valid pulse.
module tb_ann_output_classifier;

    localparam int N      = 10;
    localparam int W      = 16;
    localparam int MARGIN = 64;

    typedef logic [W-1:0] vec_t [N];
    typedef struct {
        logic [3:0] digit;
        logic       low;
        logic [7:0] seg;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ann_output_classifier_if #(.NUM_CLASSES(N), .DATA_W(W)) bus ();

    ann_output_classifier #(.NUM_CLASSES(N), .DATA_W(W), .MARGIN(16'h0040)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t       expq[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: winner is the first index holding the maximum, runner-up the max of the rest
    function automatic exp_t model(input vec_t s);
        exp_t e;
        int   v [N];
        int   b, bi, sec, diff;
        for (int i = 0; i < N; i++) v[i] = int'($signed(s[i]));
        b  = v[0];
        bi = 0;
        for (int i = 1; i < N; i++) if (v[i] > b) begin b = v[i]; bi = i; end
        sec = -(1 << (W-1));
        for (int i = 0; i < N; i++) if (i != bi && v[i] > sec) sec = v[i];
        diff    = b - sec;
        e.digit = 4'(bi);
        e.low   = (diff < MARGIN);
        e.seg   = {e.low, seg_tbl[bi]};
        e.cyc   = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.result_valid) begin
            if (expq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got digit %0h expected no pulse (t=%0t)", bus.digit, $time);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("digit",     32'(bus.digit),     32'(e.digit));
                chk("low_conf",  32'(bus.low_conf),  32'(e.low));
                chk("seven_seg", 32'(bus.seven_seg), 32'(e.seg));
                chk("latency",   32'(cyc),           32'(e.cyc));
                chk("busy_off",  32'(bus.busy),      32'd0);
            end
        end
    end

    // Issue one rising edge with scores s, hold the level, optionally blip it mid-scan
    task automatic issue(input vec_t s, input int hold, input bit blip);
        exp_t e;
        int   t;
        @(negedge clk); #2;
        for (int i = 0; i < N; i++) bus.scores[i] = s[i];
        bus.done_processing = 1'b1;
        e     = model(s);
        e.cyc = cyc + N + 2;
        expq.push_back(e);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk); #2;
            for (int i = 0; i < N; i++) bus.scores[i] = W'($urandom);
            bus.done_processing = !(blip && k == 4);
        end
        bus.done_processing = 1'b0;
        t = 0;
        while (expq.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        #2;
        chk("result_timeout", 32'(expq.size()), 32'd0);
        expq.delete();
        chk("digit_hold", 32'(bus.digit), 32'(e.digit));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        vec_t s;
        rst = 1'b1;
        bus.done_processing = 1'b0;
        bus.scores = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  32'(bus.busy),         32'd0);
        chk("rst_valid", 32'(bus.result_valid), 32'd0);
        chk("rst_digit", 32'(bus.digit),        32'd0);
        chk("rst_low",   32'(bus.low_conf),     32'd0);
        chk("rst_seg",   32'(bus.seven_seg),    32'd0);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single clear winner
        for (int i = 0; i < N; i++) s[i] = '0;
        s[7] = 16'h0100;
        issue(s, 1, 1'b0);
        // Tie: lowest index wins, zero margin
        for (int i = 0; i < N; i++) s[i] = '0;
        s[2] = 16'h0200; s[5] = 16'h0200;
        issue(s, 1, 1'b0);
        // All negative
        for (int i = 0; i < N; i++) s[i] = 16'hFF00;
        s[9] = 16'hFFF0;
        issue(s, 2, 1'b0);
        // Full-range difference
        for (int i = 0; i < N; i++) s[i] = 16'h8000;
        s[0] = 16'h7FFF;
        issue(s, 1, 1'b0);

        // Reset mid-scan at idx 4 with done held high
        for (int i = 0; i < N; i++) s[i] = W'($urandom);
        @(negedge clk); #2;
        for (int i = 0; i < N; i++) bus.scores[i] = s[i];
        bus.done_processing = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy",  32'(bus.busy),         32'd0);
        chk("abort_valid", 32'(bus.result_valid), 32'd0);
        chk("abort_digit", 32'(bus.digit),        32'd0);
        chk("abort_low",   32'(bus.low_conf),     32'd0);
        chk("abort_seg",   32'(bus.seven_seg),    32'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        repeat (20) @(negedge clk);
        #1 chk("no_start_after_rst", 32'(bus.busy), 32'd0);
        bus.done_processing = 1'b0;
        repeat (2) @(negedge clk);

        // Long hold with a mid-scan blip, then a fresh edge with new values
        for (int i = 0; i < N; i++) s[i] = W'($urandom);
        issue(s, 30, 1'b1);
        for (int i = 0; i < N; i++) s[i] = W'($urandom);
        issue(s, 1, 1'b0);

        // Randomized: mix full-range and narrow ranges that provoke ties and small margins
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < N; i++) begin
                if (r % 2 == 0) s[i] = W'($urandom);
                else            s[i] = W'(int'($urandom_range(0, 4)) * 24 - 48);
            end
            issue(s, int'($urandom_range(1, 3)), 1'b0);
        end

        repeat (5) @(negedge clk);
        chk("queue_drained", 32'(expq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
